// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST engine: FSM states, ALU opcodes,
// default polynomials and the seed/MISR helper functions.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] ALU_ADD     = 3'd0;
    localparam logic [2:0] ALU_SUB     = 3'd1;
    localparam logic [2:0] ALU_AND     = 3'd2;
    localparam logic [2:0] ALU_OR      = 3'd3;
    localparam logic [2:0] ALU_SRL     = 3'd4;
    localparam logic [2:0] ALU_SRA     = 3'd5;
    localparam logic [2:0] ALU_OP_LAST = ALU_SRA;

    localparam logic [31:0] DEF_LFSR_POLY = 32'h80200003;
    localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;

    // An all-zero seed would lock the Galois LFSR at zero forever.
    function automatic logic [31:0] fix_seed(input logic [31:0] seed);
        return (seed == 32'h0) ? 32'h1 : seed;
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] data,
                                              input logic [31:0] poly);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/alu_bist_lfsr32.sv
// 32-bit Galois LFSR operand generator; load has priority over step.
// One-cycle update latency, no backpressure (steps whenever en is high).
module lfsr32
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] POLY = DEF_LFSR_POLY,
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    output logic [31:0] q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {1'b0, r_q[31:1]} ^ (r_q[0] ? POLY : 32'h0);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/alu_bist.sv
// BIST engine for the 32-bit ALU: LFSR operands and cycling opcodes out, MISR-compacted result in.
// Run takes NUM_VECTORS+PIPE cycles after start; start is ignored while a run is in flight.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int unsigned  NUM_VECTORS = 256,
    parameter logic [31:0]  SEED_A      = 32'h80000000,
    parameter logic [31:0]  SEED_B      = 32'h00000002,
    parameter logic [31:0]  LFSR_POLY   = DEF_LFSR_POLY,
    parameter logic [31:0]  MISR_POLY   = DEF_MISR_POLY,
    parameter logic [31:0]  EXP_SIG     = 32'h00000000,
    parameter bit           PIPE        = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_ALUOp,
    input  logic [31:0] alu_C,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
);

    localparam logic [31:0] W_SEED_A   = fix_seed(SEED_A);
    localparam logic [31:0] W_SEED_B   = fix_seed(SEED_B);
    localparam logic [15:0] W_LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load;
    logic        w_step;
    logic        w_compact;
    logic        w_finish;
    logic        w_last;
    logic [15:0] r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_sig;
    logic [31:0] r_c_pipe;
    logic        r_pipe_vld;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [31:0] w_c_sel;
    logic [31:0] w_sig_nxt;

    assign w_last    = (r_cnt == W_LAST_IDX);
    assign w_c_sel   = PIPE ? r_c_pipe : alu_C;
    assign w_sig_nxt = misr_next(r_sig, w_c_sel, MISR_POLY);

    lfsr32 #(.POLY(LFSR_POLY), .SEED(W_SEED_A)) u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .en    (w_step),
        .q     (alu_A)
    );

    lfsr32 #(.POLY(LFSR_POLY), .SEED(W_SEED_B)) u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .en    (w_step),
        .q     (alu_B)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands freeze on the last vector so they stay visible in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_compact   = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                w_step    = !w_last;
                w_compact = PIPE ? r_pipe_vld : 1'b1;
                if (w_last) begin
                    w_state_nxt = PIPE ? ST_DRAIN : ST_DONE;
                    w_finish    = !PIPE;
                end
            end
            ST_DRAIN: begin
                w_compact   = 1'b1;
                w_finish    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 16'd0;
            r_op  <= ALU_ADD;
            r_sig <= 32'h0;
        end else begin
            if (w_load) begin
                r_cnt <= 16'd0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_load) begin
                r_op <= ALU_ADD;
            end else if (w_step) begin
                r_op <= (r_op == ALU_OP_LAST) ? ALU_ADD : r_op + 3'd1;
            end
            if (w_load) begin
                r_sig <= 32'h0;
            end else if (w_compact) begin
                r_sig <= w_sig_nxt;
            end
        end
    end

    // Pipelined response path: C captured every RUN cycle, compacted one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_pipe   <= 32'h0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_c_pipe   <= alu_C;
            r_pipe_vld <= (r_state == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_load) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_finish) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_sig_nxt == EXP_SIG);
        end
    end

    assign alu_ALUOp = r_op;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench: six BIST instances with different parameters, each driving a behavioural ALU.
module tb_alu_bist;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } vec_t;

    logic        clk;
    logic        rst_n [6];
    logic        start [6];
    logic [31:0] a     [6];
    logic [31:0] b     [6];
    logic [2:0]  op    [6];
    logic [31:0] c     [6];
    logic        busy  [6];
    logic        done  [6];
    logic        pass  [6];
    logic [31:0] sig   [6];

    int   checks;
    int   errors;
    vec_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        case (o)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x >> y[4:0];
            3'd5:    return $unsigned($signed(x) >>> y[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 6; i++) c[i] = alu_f(a[i], b[i], op[i]);
    end

    function automatic logic [31:0] lfsr_f(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] misr_f(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    task automatic push_vectors(input int n);
        vec_t v;
        v.a = 32'h80000000; v.b = 32'h2; v.op = 3'd0;
        sb.delete();
        for (int k = 0; k < n; k++) begin
            sb.push_back(v);
            v.a  = lfsr_f(v.a);
            v.b  = lfsr_f(v.b);
            v.op = (v.op == 3'd5) ? 3'd0 : v.op + 3'd1;
        end
    endtask

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] ma, mb, s;
        logic [2:0]  mo;
        ma = 32'h80000000; mb = 32'h2; mo = 3'd0; s = 32'h0;
        for (int k = 0; k < n; k++) begin
            s  = misr_f(s, alu_f(ma, mb, mo));
            ma = lfsr_f(ma);
            mb = lfsr_f(mb);
            mo = (mo == 3'd5) ? 3'd0 : mo + 3'd1;
        end
        return s;
    endfunction

    task automatic pulse(input int idx);
        @(negedge clk) start[idx] = 1'b1;
        @(negedge clk) start[idx] = 1'b0;
    endtask

    alu_bist #(.NUM_VECTORS(1), .EXP_SIG(32'h80000002)) u_t1 (
        .clk(clk), .reset(rst_n[0]), .start(start[0]), .alu_A(a[0]), .alu_B(b[0]), .alu_ALUOp(op[0]),
        .alu_C(c[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));
    alu_bist #(.NUM_VECTORS(2), .EXP_SIG(32'h3B3EE24C)) u_t2 (
        .clk(clk), .reset(rst_n[1]), .start(start[1]), .alu_A(a[1]), .alu_B(b[1]), .alu_ALUOp(op[1]),
        .alu_C(c[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));
    alu_bist #(.NUM_VECTORS(8)) u_t3 (
        .clk(clk), .reset(rst_n[2]), .start(start[2]), .alu_A(a[2]), .alu_B(b[2]), .alu_ALUOp(op[2]),
        .alu_C(c[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));
    alu_bist #(.NUM_VECTORS(2), .EXP_SIG(32'h3B3EE24D)) u_t4 (
        .clk(clk), .reset(rst_n[3]), .start(start[3]), .alu_A(a[3]), .alu_B(b[3]), .alu_ALUOp(op[3]),
        .alu_C(c[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));
    alu_bist #(.NUM_VECTORS(100)) u_t5 (
        .clk(clk), .reset(rst_n[4]), .start(start[4]), .alu_A(a[4]), .alu_B(b[4]), .alu_ALUOp(op[4]),
        .alu_C(c[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]), .signature(sig[4]));
    alu_bist #(.NUM_VECTORS(2), .EXP_SIG(32'h3B3EE24C), .PIPE(1'b1)) u_t6 (
        .clk(clk), .reset(rst_n[5]), .start(start[5]), .alu_A(a[5]), .alu_B(b[5]), .alu_ALUOp(op[5]),
        .alu_C(c[5]), .busy(busy[5]), .done(done[5]), .pass(pass[5]), .signature(sig[5]));

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({a[i], b[i], op[i], busy[i], done[i], pass[i], sig[i]} !== {32'h80000000, 32'h2, 3'd0, 3'b000, 32'h0}) begin
                errors++;
                $display("FAIL reset_state[%0d]: got A=%h B=%h op=%0d busy=%b done=%b pass=%b sig=%h, want A=80000000 B=2 op=0 0/0/0 sig=0",
                         i, a[i], b[i], op[i], busy[i], done[i], pass[i], sig[i]);
            end
        end
        for (int i = 0; i < 6; i++) rst_n[i] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        vec_t e;
        int   cnt;
        push_vectors(1);
        pulse(0);
        cnt = 0;
        while (busy[0] === 1'b1 && cnt < 200) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[0], b[0], op[0]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t1_vec: got %h/%h/%0d want %h/%h/%0d", a[0], b[0], op[0], e.a, e.b, e.op);
                end
                checks++;
                if (c[0] !== 32'h80000002) begin
                    errors++;
                    $display("FAIL t1_alu_c: got %h want 80000002", c[0]);
                end
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 1) begin errors++; $display("FAIL t1_busy_len: got %0d want 1", cnt); end
        checks++;
        if ({done[0], pass[0], sig[0]} !== {2'b11, 32'h80000002}) begin
            errors++;
            $display("FAIL t1_result: got done=%b pass=%b sig=%h want 1/1/80000002", done[0], pass[0], sig[0]);
        end
    endtask

    task automatic test_two;
        vec_t e;
        int   cnt;
        push_vectors(2);
        pulse(1);
        cnt = 0;
        while (busy[1] === 1'b1 && cnt < 200) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[1], b[1], op[1]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t2_vec%0d: got %h/%h/%0d want %h/%h/%0d", cnt, a[1], b[1], op[1], e.a, e.b, e.op);
                end
                if (cnt == 1) begin
                    checks++;
                    if ({a[1], b[1], op[1], c[1]} !== {32'h40000000, 32'h1, 3'd1, 32'h3FFFFFFF}) begin
                        errors++;
                        $display("FAIL t2_vec2_const: got %h/%h/%0d C=%h want 40000000/1/1 C=3FFFFFFF", a[1], b[1], op[1], c[1]);
                    end
                end
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 2) begin errors++; $display("FAIL t2_busy_len: got %0d want 2", cnt); end
        checks++;
        if ({done[1], pass[1], sig[1]} !== {2'b11, 32'h3B3EE24C}) begin
            errors++;
            $display("FAIL t2_result: got done=%b pass=%b sig=%h want 1/1/3b3ee24c", done[1], pass[1], sig[1]);
        end
    endtask

    task automatic test_opseq;
        vec_t e;
        int   cnt;
        push_vectors(8);
        pulse(2);
        cnt = 0;
        while (busy[2] === 1'b1 && cnt < 200) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[2], b[2], op[2]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t3_vec%0d: got %h/%h/%0d want %h/%h/%0d", cnt, a[2], b[2], op[2], e.a, e.b, e.op);
                end
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 8) begin errors++; $display("FAIL t3_busy_len: got %0d want 8", cnt); end
        checks++;
        if (done[2] !== 1'b1 || sig[2] !== model_sig(8)) begin
            errors++;
            $display("FAIL t3_result: got done=%b sig=%h want 1/%h", done[2], sig[2], model_sig(8));
        end
        checks++;
        if (op[2] !== 3'd1) begin errors++; $display("FAIL t3_op_hold: got %0d want 1", op[2]); end
    endtask

    task automatic test_fail_restart;
        vec_t e;
        int   cnt;
        pulse(3);
        cnt = 0;
        while (busy[3] === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
        checks++;
        if ({done[3], pass[3], sig[3]} !== {2'b10, 32'h3B3EE24C}) begin
            errors++;
            $display("FAIL t4_fail_result: got done=%b pass=%b sig=%h want 1/0/3b3ee24c", done[3], pass[3], sig[3]);
        end
        push_vectors(2);
        pulse(3);
        checks++;
        if ({busy[3], done[3], sig[3], a[3], b[3], op[3]} !== {2'b10, 32'h0, 32'h80000000, 32'h2, 3'd0}) begin
            errors++;
            $display("FAIL t4_restart: got busy=%b done=%b sig=%h A=%h B=%h op=%0d want 1/0/0/80000000/2/0",
                     busy[3], done[3], sig[3], a[3], b[3], op[3]);
        end
        cnt = 0;
        while (busy[3] === 1'b1 && cnt < 200) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[3], b[3], op[3]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t4_vec%0d: got %h/%h/%0d want %h/%h/%0d", cnt, a[3], b[3], op[3], e.a, e.b, e.op);
                end
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if ({cnt[7:0], done[3], pass[3], sig[3]} !== {8'd2, 2'b10, 32'h3B3EE24C}) begin
            errors++;
            $display("FAIL t4_rerun: got len=%0d done=%b pass=%b sig=%h want 2/1/0/3b3ee24c", cnt, done[3], pass[3], sig[3]);
        end
    endtask

    task automatic test_start_ignored;
        vec_t e;
        int   cnt;
        logic [31:0] exp_sig;
        exp_sig = model_sig(100);
        push_vectors(100);
        pulse(4);
        cnt = 0;
        while (busy[4] === 1'b1 && cnt < 400) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[4], b[4], op[4]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t5_vec%0d: got %h/%h/%0d want %h/%h/%0d", cnt, a[4], b[4], op[4], e.a, e.b, e.op);
                end
            end
            start[4] = (cnt == 10 || cnt == 50);
            cnt++;
            @(negedge clk);
        end
        start[4] = 1'b0;
        checks++;
        if (cnt !== 100) begin errors++; $display("FAIL t5_busy_len: got %0d want 100", cnt); end
        checks++;
        if ({done[4], pass[4], sig[4]} !== {1'b1, (exp_sig == 32'h0), exp_sig}) begin
            errors++;
            $display("FAIL t5_result: got done=%b pass=%b sig=%h want 1/%b/%h", done[4], pass[4], sig[4], exp_sig == 32'h0, exp_sig);
        end
    endtask

    task automatic test_reset_midrun;
        int cnt;
        pulse(4);
        cnt = 0;
        while (busy[4] === 1'b1 && cnt < 37) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt !== 37 || sig[4] === 32'h0) begin
            errors++;
            $display("FAIL t5_midrun: got cycles=%0d sig=%h want 37 cycles, nonzero sig", cnt, sig[4]);
        end
        rst_n[4] = 1'b0;
        @(negedge clk);
        checks++;
        if ({a[4], b[4], op[4], busy[4], done[4], pass[4], sig[4]} !== {32'h80000000, 32'h2, 3'd0, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL t5_abort: got A=%h B=%h op=%0d busy=%b done=%b pass=%b sig=%h want reset values",
                     a[4], b[4], op[4], busy[4], done[4], pass[4], sig[4]);
        end
        rst_n[4] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy[4], done[4], sig[4]} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL t5_idle_after_abort: got busy=%b done=%b sig=%h want 0/0/0", busy[4], done[4], sig[4]);
        end
    endtask

    task automatic test_pipe;
        vec_t e;
        int   cnt;
        push_vectors(2);
        pulse(5);
        cnt = 0;
        while (busy[5] === 1'b1 && cnt < 200) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({a[5], b[5], op[5]} !== {e.a, e.b, e.op}) begin
                    errors++;
                    $display("FAIL t6_vec%0d: got %h/%h/%0d want %h/%h/%0d", cnt, a[5], b[5], op[5], e.a, e.b, e.op);
                end
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 3) begin errors++; $display("FAIL t6_busy_len: got %0d want 3", cnt); end
        checks++;
        if ({done[5], pass[5], sig[5]} !== {2'b11, 32'h3B3EE24C}) begin
            errors++;
            $display("FAIL t6_result: got done=%b pass=%b sig=%h want 1/1/3b3ee24c", done[5], pass[5], sig[5]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 6; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_two();
        test_opseq();
        test_fail_restart();
        test_start_ignored();
        test_reset_midrun();
        test_pipe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
